// File: rtl/mult_pkg.sv
// Shared types and defaults for the round-robin multiplier arbiter.
// Holds the FSM state enum, default sizes and a width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N    = 16;
    localparam int DEF_NREQ = 4;

    // ceil(log2(v)), never less than 1 so index ports stay legal
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int DEF_IDW = clog2(DEF_NREQ);

endpackage

// File: rtl/mult_core.sv
// Sequential shift-add multiplier datapath, one partial product per step.
// load captures operands and clears the accumulator; done flags the last step.
module mult_core
    import mult_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] acc,
    output logic           done
);

    localparam int CW = clog2(N);

    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] w_addend;
    logic           w_last;

    // A shifted to the current bit position at full product width
    assign w_addend = {{N{1'b0}}, r_a} << r_cnt;
    assign w_last   = (r_cnt == CW'(N - 1));
    assign done     = step && w_last;
    assign acc      = r_acc;

    // Operand capture and one conditional add per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (load) begin
            r_a   <= a;
            r_b   <= b;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (step) begin
            if (r_b[r_cnt]) r_acc <= r_acc + w_addend;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one shift-add multiplier among NREQ requesters.
// Define MULT_ARB_ZERO_SKIP_EN to bypass the RUN phase for zero operands.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter  int N    = DEF_N,
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*N-1:0]    rsp_q,
    output logic              busy
);

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_gid;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_valid;

    logic             w_found;
    logic [IDW-1:0]   w_gnt;
    logic             w_take;
    logic [N-1:0]     w_a;
    logic [N-1:0]     w_b;
    logic             w_zero;
    logic             w_step;
    logic             w_done;
    logic [2*N-1:0]   w_acc;
    logic [IDW-1:0]   w_ptr_nxt;

    // First valid requester at or after the pointer, wrapping to 0
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_gnt   = '0;
        v_idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            v_idx = int'(r_ptr) + i;
            if (v_idx >= NREQ) v_idx = v_idx - NREQ;
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_gnt   = IDW'(v_idx);
            end
        end
    end

    assign w_take    = rst_n && (r_state == IDLE) && w_found;
    assign req_ready = w_take ? (NREQ'(1) << w_gnt) : '0;
    assign w_a       = req_a[int'(w_gnt)*N +: N];
    assign w_b       = req_b[int'(w_gnt)*N +: N];
    assign w_step    = (r_state == RUN);
    assign w_ptr_nxt = (r_gid == IDW'(NREQ - 1)) ? '0 : r_gid + 1'b1;

`ifdef MULT_ARB_ZERO_SKIP_EN
    assign w_zero = (w_a == '0) || (w_b == '0);
`else
    assign w_zero = 1'b0;
`endif

    mult_core #(
        .N (N)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_take),
        .step  (w_step),
        .a     (w_a),
        .b     (w_b),
        .acc   (w_acc),
        .done  (w_done)
    );

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_q     = w_acc;
    assign busy      = (r_state != IDLE);

    // Control FSM: grant, run N steps, hold result until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gid       <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gid <= w_gnt;
                        if (w_zero) begin
                            r_state     <= DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_id    <= w_gnt;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_done) begin
                        r_state     <= DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_gid;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= w_ptr_nxt;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: latency, products, fairness, backpressure.
// Expected values are hand-computed constants.
module tb_mult_arbiter;

    localparam int N    = 16;
    localparam int NREQ = 4;

`ifdef MULT_ARB_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 17;
`endif

    logic          clk;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [63:0]   req_a;
    logic [63:0]   req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_q;
    logic          busy;

    int errors;
    int checks;

    mult_arbiter #(
        .N    (N),
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; caller is 1 time unit after a rising edge
    task automatic run_one(input logic [3:0] v, input logic [15:0] a,
                           input logic [15:0] b, input int g,
                           input logic [31:0] q, input int lat,
                           input int hold, input bit rr_early);
        int cyc;
        req_valid = v;
        req_a     = {4{a}};
        req_b     = {4{b}};
        rsp_ready = rr_early;
        #1;
        chk("grant", 64'(req_ready), 64'(4'b0001 << g));
        tick();
        req_valid = '0;
        req_a     = '1;
        req_b     = '1;
        chk("ready_off", 64'(req_ready), 64'd0);
        chk("busy_run", 64'(busy), 64'd1);
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(lat));
        chk("rsp_q", 64'(rsp_q), 64'(q));
        chk("rsp_id", 64'(rsp_id), 64'(g));
        for (int h = 0; h < hold; h++) begin
            req_valid = '1;
            tick();
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_q", 64'(rsp_q), 64'(q));
            chk("hold_id", 64'(rsp_id), 64'(g));
            chk("hold_busy", 64'(busy), 64'd1);
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_valid", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int gcnt;
        int rcnt;
        int gid [5];
        int gcyc [5];
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #2;
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_q", 64'(rsp_q), 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        tick();
        tick();
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        run_one(4'b0001, 16'd3, 16'd5, 0, 32'd15, 17, 0, 1'b1);
        run_one(4'b0001, 16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001, 17, 0, 1'b0);
        run_one(4'b0100, 16'h1234, 16'h5678, 2, 32'h06260060, 17, 0, 1'b0);
        run_one(4'b1000, 16'd0, 16'd7, 3, 32'd0, ZLAT, 0, 1'b0);
        run_one(4'b0010, 16'd7, 16'd9, 1, 32'd63, 17, 10, 1'b0);

        req_valid = 4'b1111;
        req_a     = {4{16'd2}};
        req_b     = {4{16'd2}};
        #1;
        chk("rr_ptr2", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        repeat (7) tick();
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n     = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_q", 64'(rsp_q), 64'd0);
        chk("mid_rst_id", 64'(rsp_id), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        run_one(4'b1010, 16'd4, 16'd4, 1, 32'd16, 17, 0, 1'b0);

        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            req_a[k*16 +: 16] = 16'(k + 1);
            req_b[k*16 +: 16] = 16'd10;
        end
        rsp_ready = 1'b1;
        gcnt = 0;
        rcnt = 0;
        for (int c = 0; c < 150 && gcnt < 5; c++) begin
            #1;
            if (req_ready != 4'b0000) begin
                gid[gcnt]  = (req_ready == 4'b0010) ? 1 :
                             (req_ready == 4'b0100) ? 2 :
                             (req_ready == 4'b1000) ? 3 :
                             (req_ready == 4'b0001) ? 0 : 9;
                gcyc[gcnt] = c;
                gcnt++;
            end
            if (rsp_valid && rcnt < 4) begin
                chk("fair_id", 64'(rsp_id), 64'(rcnt % 4));
                chk("fair_q", 64'(rsp_q), 64'(((rcnt % 4) + 1) * 10));
                rcnt++;
            end
            @(posedge clk);
        end
        #1;
        chk("fair_count", 64'(gcnt), 64'd5);
        for (int i = 0; i < gcnt; i++) begin
            chk("fair_order", 64'(gid[i]), 64'(i % 4));
            if (i > 0) chk("fair_gap", 64'(gcyc[i] - gcyc[i-1]), 64'd18);
        end
        req_valid = '0;
        rsp_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N, default 16, operand width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters; IDW = clog2(NREQ).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NREQ  per-requester operand-valid flag.
REQ-006 req_ready  output  NREQ  per-requester accept strobe, one-hot or zero.
REQ-007 req_a  input  NREQ*N  packed multiplicands; slice k belongs to requester k.
REQ-008 req_b  input  NREQ*N  packed multipliers; slice k belongs to requester k.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  IDW  index of the requester that owns rsp_q.
REQ-012 rsp_q  output  2N  unsigned product A*B.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-015 In IDLE with any req_valid high, the block SHALL select the grant g by round-robin, starting the search at pointer ptr and wrapping from NREQ-1 to 0.
REQ-016 In that same cycle, req_ready[g] SHALL be high combinationally, req_a/req_b slice g and g SHALL be captured, and the next state SHALL be RUN.
REQ-017 req_ready SHALL be all-zero outside IDLE; a request is transferred only when req_valid[k] && req_ready[k].
REQ-018 RUN SHALL perform one shift-add step per cycle for exactly N cycles, driven by a step counter 0..N-1: if bit i of B is 1, acc += A<<i, with the add done at 2N-bit width and no overflow possible.
REQ-019 After step N-1 the state SHALL become DONE, with rsp_valid=1, rsp_q=product and rsp_id=g.
REQ-020 Latency SHALL be: acceptance in cycle 0, rsp_valid rising in cycle N+1.
REQ-021 rsp_q, rsp_id and rsp_valid SHALL hold stable in DONE until rsp_ready is high.
REQ-022 On rsp_valid && rsp_ready, the next state SHALL be IDLE and ptr SHALL become (g+1) mod NREQ.
REQ-023 A new request SHALL NOT be accepted in the same cycle that a response is accepted; the minimum issue interval is N+2 cycles.
REQ-024 Changes to req_valid, req_a or req_b after acceptance SHALL NOT affect the running operation.
REQ-025 A requester that deasserts req_valid before it is granted SHALL simply be skipped; there is no penalty and ptr is unchanged.
REQ-026 rsp_ready high while rsp_valid is low SHALL have no effect.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately set state=IDLE, ptr=0, step counter=0, accumulator=0, rsp_valid=0, rsp_q=0, rsp_id=0, busy=0 and req_ready=0.
REQ-028 Reset mid-RUN or mid-DONE SHALL discard the operation without producing a response; the first grant after release SHALL follow ptr=0.

Configuration
REQ-029 Macro MULT_ARB_ZERO_SKIP_EN: when defined, a captured operand pair with A==0 or B==0 SHALL go from IDLE directly to DONE with rsp_q=0, so rsp_valid rises in cycle 1.
REQ-030 When MULT_ARB_ZERO_SKIP_EN is undefined, zero operands SHALL take the full N-cycle RUN like any other pair.

Structure
REQ-031 Package mult_pkg SHALL hold the state enum (IDLE/RUN/DONE), the default N and NREQ, and the IDW function/constant.
REQ-032 The datapath SHALL be the sub-module mult_core (inputs load, step, a, b; outputs acc, done).
REQ-033 mult_arbiter SHALL own the FSM, round-robin pointer and handshakes.

Verification
REQ-034 Single request: req_valid=4'b0001, A=3, B=5 -> req_ready[0] pulses once; rsp_valid rises in cycle 17; rsp_q=15, rsp_id=0.
REQ-035 Max operands: A=B=16'hFFFF -> rsp_q=32'hFFFE0001.
REQ-036 Fairness: all four req_valid held high with rsp_ready=1 -> grant order is 0,1,2,3,0, and each issue is 18 cycles apart.
REQ-037 Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_q/rsp_id are stable, busy=1, and req_ready stays 0 throughout.
REQ-038 Reset in RUN cycle 8 -> all outputs are 0 at once; the next grant with req_valid=4'b1010 goes to requester 1.
REQ-039 Zero operand A=0, B=7 -> rsp_q=0 in cycle 1 with MULT_ARB_ZERO_SKIP_EN defined, and in cycle 17 without it.
